// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature RPM meter.
package quad_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_t;

  // Fraction width of the fixed-point RPM scale factor.
  localparam int unsigned SCALE_FRAC_W = 16;

  // Position of an {A,B} state along the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    unique case (ab)
      2'b00:   gray_idx = 2'd0;
      2'b01:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature front end: 2-flop synchronizer, optional 3-sample glitch filter
// (QUAD_GLITCH_FILTER_EN), and per-cycle step decode against the previous sample.
module quad_decoder
  import quad_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_qa,
  input  logic  i_qb,
  output step_t o_step
);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] cur;
  logic [1:0] prev;
  logic [1:0] diff;

  always_ff @(posedge i_clk) begin
    sync1 <= {i_qa, i_qb};
    sync2 <= sync1;
  end

`ifdef QUAD_GLITCH_FILTER_EN
  logic [1:0] hist1;
  logic [1:0] hist2;
  logic [1:0] held;
  logic [1:0] filt;

  always_ff @(posedge i_clk) begin
    hist1 <= sync2;
    hist2 <= hist1;
    held  <= filt;
  end

  // A channel follows its input only once three consecutive samples agree.
  always_comb begin
    filt = held;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2[i] == hist1[i] && hist1[i] == hist2[i]) filt[i] = sync2[i];
    end
  end

  assign cur = filt;
`else
  assign cur = sync2;
`endif

  // Tracks the input even during reset, so release never decodes a step.
  always_ff @(posedge i_clk) begin
    prev <= cur;
  end

  always_comb begin
    o_step = STEP_NONE;
    diff   = gray_idx(cur) - gray_idx(prev);
    unique case (diff)
      2'd1:    o_step = STEP_FWD;
      2'd3:    o_step = STEP_REV;
      2'd2:    o_step = STEP_ILLEGAL;
      default: o_step = STEP_NONE;
    endcase
  end

endmodule

// File: rtl/quad_rpm_meter.sv
// Quadrature encoder RPM meter: windowed edge count scaled to RPM, running
// position, direction and sticky error. Glitch filter via QUAD_GLITCH_FILTER_EN.
module quad_rpm_meter
  import quad_pkg::*;
#(
  parameter int T_CLK     = 10,
  parameter int WINDOW_MS = 10,
  parameter int CPR       = 2048
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_qa,
  input  logic               i_qb,
  output logic signed [31:0] o_rpm,
  output logic               o_rpm_valid,
  output logic signed [31:0] o_position,
  output logic               o_dir,
  output logic               o_error
);

  localparam int unsigned C_M     = WINDOW_MS * 1_000_000 / T_CLK;
  localparam longint      SCALE   = (longint'(60000) << SCALE_FRAC_W) / longint'(WINDOW_MS * CPR);
  localparam logic signed [47:0] SCALE_S = 48'(SCALE);
  localparam logic [31:0] TICK_AT = 32'(C_M - 1);

  step_t              step;
  logic signed [1:0]  step_val;
  logic [31:0]        timer;
  logic               tick;
  logic signed [23:0] win_cnt;
  logic signed [23:0] win_sat;
  logic signed [24:0] sum;
  logic signed [23:0] latched;
  logic               lat_vld;
  logic signed [47:0] prod;
  logic signed [31:0] rpm_calc;

  quad_decoder u_dec (
    .i_clk  (i_clk),
    .i_qa   (i_qa),
    .i_qb   (i_qb),
    .o_step (step)
  );

  assign tick = (timer == TICK_AT);

  always_comb begin
    step_val = 2'sd0;
    unique case (step)
      STEP_FWD: step_val = 2'sd1;
      STEP_REV: step_val = 2'b11;
      default:  step_val = 2'sd0;
    endcase
  end

  always_comb begin
    sum = 25'(win_cnt) + 25'(step_val);
    if (sum > 25'sd8388607)       win_sat = 24'sh7FFFFF;
    else if (sum < -25'sd8388608) win_sat = 24'sh800000;
    else                          win_sat = sum[23:0];
  end

  always_comb begin
    prod     = 48'(latched) * SCALE_S;
    rpm_calc = 32'(prod >>> SCALE_FRAC_W);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer       <= '0;
      win_cnt     <= '0;
      latched     <= '0;
      lat_vld     <= 1'b0;
      o_rpm       <= '0;
      o_rpm_valid <= 1'b0;
      o_position  <= '0;
      o_dir       <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      timer <= tick ? '0 : timer + 32'd1;
      // The tick cycle's own step seeds the next window, not the latched one.
      if (tick) begin
        latched <= win_cnt;
        win_cnt <= 24'(step_val);
      end else begin
        win_cnt <= win_sat;
      end
      lat_vld     <= tick;
      o_rpm_valid <= lat_vld;
      if (lat_vld) o_rpm <= rpm_calc;
      unique case (step)
        STEP_FWD: begin
          o_position <= o_position + 32'sd1;
          o_dir      <= 1'b1;
        end
        STEP_REV: begin
          o_position <= o_position - 32'sd1;
          o_dir      <= 1'b0;
        end
        STEP_ILLEGAL: o_error <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_rpm_meter.sv
// Randomized self-checking bench for quad_rpm_meter against a windowed edge-count model.
module tb_quad_rpm_meter;

  localparam int C_M   = 1000;
  localparam longint SCALE = 1920000;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_qa;
  logic        i_qb;
  logic signed [31:0] o_rpm;
  logic        o_rpm_valid;
  logic signed [31:0] o_position;
  logic        o_dir;
  logic        o_error;

  quad_rpm_meter #(.T_CLK(1000), .WINDOW_MS(1), .CPR(2048)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_qa        (i_qa),
    .i_qb        (i_qb),
    .o_rpm       (o_rpm),
    .o_rpm_valid (o_rpm_valid),
    .o_position  (o_position),
    .o_dir       (o_dir),
    .o_error     (o_error)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;

  int  n   = 0;
  bit  run = 1'b0;
  int  win_exp [int];
  int  m_pos   = 0;
  int  m_dir   = 0;
  int  m_err   = 0;
  int  run_a   = 0;
  int  run_b   = 0;
  logic last_a = 1'b0, last_b = 1'b0;
  logic eff_a  = 1'b0, eff_b  = 1'b0;
  logic [1:0] peff = 2'b00;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int  pidx = 0;
  logic [1:0] cur = 2'b00;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int rpm_of(input int cnt);
    longint p, q;
    p = longint'(cnt) * SCALE;
    q = p / 65536;
    if (p < 0 && (p % 65536) != 0) q = q - 1;
    return int'(q);
  endfunction

  // One clock: drive raw inputs, then apply the decode rules to the model.
  task automatic step_clk(input logic [1:0] ab);
    int d, s, a;
    @(posedge i_clk);
    n++;
    #1;
    i_qa = ab[1];
    i_qb = ab[0];
    run_a  = (ab[1] == last_a) ? run_a + 1 : 1;
    run_b  = (ab[0] == last_b) ? run_b + 1 : 1;
    last_a = ab[1];
    last_b = ab[0];
`ifdef QUAD_GLITCH_FILTER_EN
    if (run_a >= 3) eff_a = ab[1];
    if (run_b >= 3) eff_b = ab[0];
`else
    eff_a = ab[1];
    eff_b = ab[0];
`endif
    if ({eff_a, eff_b} != peff) begin
      d = (gidx({eff_a, eff_b}) - gidx(peff) + 4) % 4;
      if (d == 2) m_err = 1;
      else begin
        s = (d == 1) ? 1 : -1;
        m_pos = m_pos + s;
        m_dir = (s > 0) ? 1 : 0;
        a = (n + 3) / C_M + 1;
        if (win_exp.exists(a)) win_exp[a] = win_exp[a] + s;
        else win_exp[a] = s;
      end
      peff = {eff_a, eff_b};
    end
  endtask

  task automatic hold(input int cycles);
    for (int i = 0; i < cycles; i++) step_clk(cur);
  endtask

  task automatic mv(input int s, input int cyc);
    pidx = (pidx + 4 + s) % 4;
    cur  = seq[pidx];
    hold(cyc);
  endtask

  task automatic quiet_check(input string tag);
    check({tag, "_pos"}, o_position, m_pos);
    check({tag, "_dir"}, int'(o_dir), m_dir);
    check({tag, "_err"}, int'(o_error), m_err);
  endtask

  task automatic do_reset();
    run   = 1'b0;
    i_rst = 1'b1;
    hold(8);
    i_rst = 1'b0;
    n     = 0;
    win_exp.delete();
    m_pos = 0;
    m_dir = 0;
    m_err = 0;
    peff  = {eff_a, eff_b};
    run   = 1'b1;
    check("rst_rpm", o_rpm, 0);
    check("rst_valid", int'(o_rpm_valid), 0);
    check("rst_pos", o_position, 0);
    check("rst_dir", int'(o_dir), 0);
    check("rst_err", int'(o_error), 0);
  endtask

  always @(negedge i_clk) begin
    if (run) begin
      automatic bit exp_v = (n > C_M) && (n % C_M == 1);
      check("valid", int'(o_rpm_valid), int'(exp_v));
      if (exp_v) begin
        automatic int j = (n - 1) / C_M;
        automatic int c = win_exp.exists(j) ? win_exp[j] : 0;
        check("rpm", o_rpm, rpm_of(c));
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_qa  = 1'b0;
    i_qb  = 1'b0;
    do_reset();

    // Steady forward then reverse rotation: 100 edges per window.
    for (int i = 0; i < 250; i++) mv(1, 10);
    quiet_check("fwd");
    for (int i = 0; i < 250; i++) mv(-1, 10);
    quiet_check("rev");

    // Random legal motion.
    for (int i = 0; i < 300; i++) begin
      automatic int h = $urandom_range(3, 15);
      mv(($urandom_range(0, 2) == 2) ? -1 : 1, h);
      if (h >= 8) quiet_check("rnd");
    end

    // Edge counted exactly on the reload cycle, then on the last cycle of a window.
    for (int i = 0; i < 2 * C_M && ((n + 1 + LAT) % C_M) != 0; i++) step_clk(cur);
    mv(1, 20);
    for (int i = 0; i < 2 * C_M && ((n + 1 + LAT) % C_M) != C_M - 1; i++) step_clk(cur);
    mv(1, 20);
    quiet_check("tick");

    // Both channels flip together: sticky error, no count.
    pidx = (pidx + 2) % 4;
    cur  = seq[pidx];
    hold(10);
    check("illegal_err", int'(o_error), 1);
    for (int i = 0; i < 20; i++) mv(1, 6);
    hold(8);
    quiet_check("post_illegal");

    // Single-cycle glitch on A.
    begin
      automatic int pos_before = m_pos;
      automatic logic [1:0] g = cur;
      g[1] = ~g[1];
      step_clk(g);
      hold(12);
      check("glitch_pos", o_position, pos_before);
      quiet_check("glitch");
    end

    // Reset halfway through a window discards it.
    for (int i = 0; i < 2 * C_M && (n % C_M) != 500; i++) step_clk(cur);
    do_reset();
    for (int i = 0; i < 250; i++) mv(($urandom_range(0, 3) == 0) ? -1 : 1, $urandom_range(3, 12));
    for (int i = 0; i < 3 * C_M && n <= 2 * C_M + 5; i++) step_clk(cur);
    quiet_check("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
